store_queue_fwd: RTL

//  Parametrised circular store queue: WAYS-wide in-order allocate, address/data resolution, COMMIT_W-wide retire.

---
 rtl/store_queue_fwd_pkg.sv | 53 +++++
 rtl/store_queue_fwd_if.sv | 58 +++++
 rtl/store_queue_fwd_lookup.sv | 66 ++++++
 rtl/store_queue_fwd.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/store_queue_fwd_pkg.sv
// Shared types for the store queue: entry record, memory size and entry lifecycle state.
// Entry fields are sized for the widest supported configuration; narrower ports zero-extend.
package store_queue_fwd_pkg;

  localparam int unsigned SQ_ADDR_W = 32;
  localparam int unsigned SQ_ROB_W  = 8;
  localparam int unsigned SQ_PRF_W  = 8;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RETIRED = 2'd2
  } st_state_e;

  typedef struct packed {
    mem_size_e             size;
    logic [SQ_ADDR_W-1:0]  addr;
    logic                  addr_valid;
    logic [31:0]           data;
    logic                  data_valid;
    logic [SQ_PRF_W-1:0]   PRF_idx;
    logic [SQ_ROB_W-1:0]   ROB_idx;
    st_state_e             state;
  } sq_entry_t;

  // Byte lanes touched within the aligned word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_queue_fwd_if.sv
// Store queue bus bundle: dispatch, wakeup, address resolve, retire, DCache drain and load probe.
interface store_queue_fwd_if #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned ROB_SZ   = 32,
  parameter int unsigned PRF_SZ   = 64,
  parameter int unsigned AW       = 16
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(ROB_SZ);
  localparam int unsigned PW = $clog2(PRF_SZ);
  localparam int unsigned CW = $clog2(COMMIT_W + 1);

  logic                 except;
  logic [WAYS-1:0]      st_en;
  logic [WAYS*2-1:0]    st_size;
  logic [WAYS*RW-1:0]   st_ROB_idx;
  logic [WAYS*PW-1:0]   st_PRF_idx;
  logic [WAYS*32-1:0]   st_data;
  logic [WAYS-1:0]      st_data_valid;
  logic [WAYS-1:0]      CDB_valid;
  logic [WAYS*PW-1:0]   CDB_PRF_idx;
  logic [WAYS*32-1:0]   CDB_Data;
  logic [WAYS-1:0]      ALU_is_valid;
  logic [WAYS-1:0]      ALU_is_store;
  logic [WAYS*RW-1:0]   ALU_ROB_idx;
  logic [WAYS*AW-1:0]   ALU_addr;
  logic [CW-1:0]        commit_num;
  logic                 wr_ready;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [31:0]          wr_data;
  logic [1:0]           wr_size;
  logic                 ld_probe_en;
  logic [AW-1:0]        ld_addr;
  logic [1:0]           ld_size;
  logic [IW-1:0]        ld_sq_tail;
  logic                 fwd_hit;
  logic                 fwd_stall;
  logic [31:0]          fwd_data;
  logic [IW-1:0]        sq_tail;
  logic [IW:0]          num_free;

  modport master (
    output except, st_en, st_size, st_ROB_idx, st_PRF_idx, st_data, st_data_valid,
           CDB_valid, CDB_PRF_idx, CDB_Data, ALU_is_valid, ALU_is_store, ALU_ROB_idx,
           ALU_addr, commit_num, wr_ready, ld_probe_en, ld_addr, ld_size, ld_sq_tail,
    input  wr_en, wr_addr, wr_data, wr_size, fwd_hit, fwd_stall, fwd_data, sq_tail, num_free
  );

  modport slave (
    input  except, st_en, st_size, st_ROB_idx, st_PRF_idx, st_data, st_data_valid,
           CDB_valid, CDB_PRF_idx, CDB_Data, ALU_is_valid, ALU_is_store, ALU_ROB_idx,
           ALU_addr, commit_num, wr_ready, ld_probe_en, ld_addr, ld_size, ld_sq_tail,
    output wr_en, wr_addr, wr_data, wr_size, fwd_hit, fwd_stall, fwd_data, sq_tail, num_free
  );
endinterface

// File: rtl/store_queue_fwd_lookup.sv
// Store-to-load forwarding search: walks stores older than the load's tail snapshot,
// oldest to youngest, so the youngest overlapping store decides hit versus stall.
module sq_fwd_lookup
  import store_queue_fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 16
) (
  input  sq_entry_t                 entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic                      full,
  input  logic                      probe_en,
  input  logic [AW-1:0]             ld_addr,
  input  logic [1:0]                ld_size,
  input  logic [$clog2(DEPTH)-1:0]  ld_sq_tail,
  output logic                      fwd_hit,
  output logic                      fwd_stall,
  output logic [31:0]               fwd_data
);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [IW:0]          older_n;
  logic [IW-1:0]        idx;
  logic [3:0]           ld_mask;
  logic [3:0]           st_mask;
  logic                 addr_miss;
  logic                 found;
  logic                 covers;
  logic [31:0]          lane;
  logic [SQ_ADDR_W-1:0] ld_word;

  always_comb begin
    older_n   = {1'b0, ld_sq_tail - head};
    // tail == head is ambiguous; a full queue means every entry is older
    if (ld_sq_tail == head && full) older_n = (IW+1)'(DEPTH);
    idx       = '0;
    st_mask   = '0;
    addr_miss = 1'b0;
    found     = 1'b0;
    covers    = 1'b0;
    lane      = '0;
    ld_mask   = byte_mask(ld_size, ld_addr[1:0]);
    ld_word   = SQ_ADDR_W'(ld_addr) >> 2;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + IW'(i);
      if ((IW+1)'(i) < older_n && entries[idx].state != ST_FREE) begin
        if (!entries[idx].addr_valid) begin
          addr_miss = 1'b1;
        end else begin
          st_mask = byte_mask(entries[idx].size, entries[idx].addr[1:0]);
          if ((entries[idx].addr >> 2) == ld_word && (st_mask & ld_mask) != 4'b0000) begin
            found  = 1'b1;
            covers = ((ld_mask & ~st_mask) == 4'b0000) && entries[idx].data_valid;
            lane   = (entries[idx].data & size_mask(entries[idx].size))
                     << {entries[idx].addr[1:0], 3'b000};
          end
        end
      end
    end
    fwd_hit   = probe_en && !addr_miss && found && covers;
    fwd_stall = probe_en && (addr_miss || (found && !covers));
    fwd_data  = '0;
    if (fwd_hit) fwd_data = (lane >> {ld_addr[1:0], 3'b000}) & size_mask(ld_size);
  end

endmodule

// File: rtl/store_queue_fwd.sv
// Circular store queue: in-order multi-way allocate, CDB/ALU resolution, multi-wide retire,
// single-pop DCache drain and combinational store-to-load forwarding probe.
module store_queue_fwd
  import store_queue_fwd_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned ROB_SZ   = 32,
  parameter int unsigned PRF_SZ   = 64,
  parameter int unsigned AW       = 16
) (
  input  logic             clock,
  input  logic             reset,
  store_queue_fwd_if.slave sq
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(ROB_SZ);
  localparam int unsigned PW = $clog2(PRF_SZ);
  localparam int unsigned CW = $clog2(COMMIT_W + 1);
  localparam int unsigned NW = IW + 1;

  sq_entry_t     entries_q [DEPTH];
  sq_entry_t     entries_d [DEPTH];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] ret_q, ret_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [NW-1:0] num_free_q, num_free_d;
  logic [NW-1:0] num_pend_q, num_pend_d;

  logic          pop;
  logic          full;
  logic          commit_ok;
  logic [NW-1:0] alloc_n;
  logic [NW-1:0] pend_after;
  logic [IW-1:0] idx;
  sq_entry_t     ne;

  assign full = (num_free_q == '0);

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    ret_d      = ret_q;
    tail_d     = tail_q;
    num_free_d = num_free_q;
    num_pend_d = num_pend_q;
    alloc_n    = '0;
    idx        = '0;
    ne         = '0;
    commit_ok  = 1'b1;
    pop        = (entries_q[head_q].state == ST_RETIRED) && sq.wr_ready;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries_q[i].state == ST_PENDING) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (!entries_q[i].data_valid && sq.CDB_valid[w] &&
              entries_q[i].PRF_idx == SQ_PRF_W'(sq.CDB_PRF_idx[w*PW +: PW])) begin
            entries_d[i].data       = sq.CDB_Data[w*32 +: 32];
            entries_d[i].data_valid = 1'b1;
          end
          if (sq.ALU_is_valid[w] && sq.ALU_is_store[w] &&
              entries_q[i].ROB_idx == SQ_ROB_W'(sq.ALU_ROB_idx[w*RW +: RW])) begin
            entries_d[i].addr       = SQ_ADDR_W'(sq.ALU_addr[w*AW +: AW]);
            entries_d[i].addr_valid = 1'b1;
          end
        end
      end
    end

    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (CW'(k) < sq.commit_num) begin
        idx = ret_q + IW'(k);
        entries_d[idx].state = ST_RETIRED;
        if (entries_q[idx].state != ST_PENDING || !entries_q[idx].addr_valid ||
            !entries_q[idx].data_valid) commit_ok = 1'b0;
      end
    end
    ret_d      = ret_q + IW'(sq.commit_num);
    pend_after = num_pend_q - NW'(sq.commit_num);

    if (pop) begin
      entries_d[head_q].state      = ST_FREE;
      entries_d[head_q].addr_valid = 1'b0;
      entries_d[head_q].data_valid = 1'b0;
      head_d = head_q + IW'(1);
    end

    if (sq.except) begin
      // commit above has already moved its entries out of PENDING, so they survive
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (entries_d[i].state == ST_PENDING) begin
          entries_d[i].state      = ST_FREE;
          entries_d[i].addr_valid = 1'b0;
          entries_d[i].data_valid = 1'b0;
        end
      end
      tail_d     = ret_d;
      num_pend_d = '0;
      num_free_d = num_free_q + NW'(pop) + pend_after;
    end else begin
      // slots come from the registered free count, so a same-cycle pop is not reused
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (sq.st_en[w] && alloc_n < num_free_q) begin
          ne            = '0;
          ne.state      = ST_PENDING;
          ne.size       = mem_size_e'(sq.st_size[w*2 +: 2]);
          ne.ROB_idx    = SQ_ROB_W'(sq.st_ROB_idx[w*RW +: RW]);
          ne.PRF_idx    = SQ_PRF_W'(sq.st_PRF_idx[w*PW +: PW]);
          ne.data       = sq.st_data[w*32 +: 32];
          ne.data_valid = sq.st_data_valid[w];
          for (int unsigned v = 0; v < WAYS; v++) begin
            if (!sq.st_data_valid[w] && sq.CDB_valid[v] &&
                sq.st_PRF_idx[w*PW +: PW] == sq.CDB_PRF_idx[v*PW +: PW]) begin
              ne.data       = sq.CDB_Data[v*32 +: 32];
              ne.data_valid = 1'b1;
            end
            if (sq.ALU_is_valid[v] && sq.ALU_is_store[v] &&
                sq.st_ROB_idx[w*RW +: RW] == sq.ALU_ROB_idx[v*RW +: RW]) begin
              ne.addr       = SQ_ADDR_W'(sq.ALU_addr[v*AW +: AW]);
              ne.addr_valid = 1'b1;
            end
          end
          idx            = tail_q + IW'(alloc_n);
          entries_d[idx] = ne;
          alloc_n        = alloc_n + NW'(1);
        end
      end
      tail_d     = tail_q + IW'(alloc_n);
      num_pend_d = pend_after + alloc_n;
      num_free_d = num_free_q + NW'(pop) - alloc_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q     <= '0;
      ret_q      <= '0;
      tail_q     <= '0;
      num_free_q <= NW'(DEPTH);
      num_pend_q <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      ret_q      <= ret_d;
      tail_q     <= tail_d;
      num_free_q <= num_free_d;
      num_pend_q <= num_pend_d;
    end
  end

  assign sq.wr_en    = (entries_q[head_q].state == ST_RETIRED);
  assign sq.wr_addr  = entries_q[head_q].addr[AW-1:0];
  assign sq.wr_data  = entries_q[head_q].data;
  assign sq.wr_size  = entries_q[head_q].size;
  assign sq.sq_tail  = tail_q;
  assign sq.num_free = num_free_q;

  sq_fwd_lookup #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .entries    (entries_q),
    .head       (head_q),
    .full       (full),
    .probe_en   (sq.ld_probe_en),
    .ld_addr    (sq.ld_addr),
    .ld_size    (sq.ld_size),
    .ld_sq_tail (sq.ld_sq_tail),
    .fwd_hit    (sq.fwd_hit),
    .fwd_stall  (sq.fwd_stall),
    .fwd_data   (sq.fwd_data)
  );

  a_alloc_fits: assert property (@(posedge clock) disable iff (reset)
    (!sq.except && !full) |-> (NW'($countones(sq.st_en)) <= num_free_q));
  a_commit_count: assert property (@(posedge clock) disable iff (reset)
    (NW'(sq.commit_num) <= num_pend_q));
  a_commit_ready: assert property (@(posedge clock) disable iff (reset) commit_ok);

endmodule
